// File: rtl/regseq_pkg.sv
// regseq_pkg: shared types, defaults and helpers for the register file
// sequencer (instruction field positions, opcode and FSM state encodings).
package regseq_pkg;

  localparam int DW_DEF = 10;
  localparam int AW_DEF = 3;

  // Instruction word layout: op[9:8] rx[7:5] ry[4:2], bits [1:0] reserved
  localparam int OP_MSB = 9;
  localparam int OP_LSB = 8;
  localparam int RX_MSB = 7;
  localparam int RX_LSB = 5;
  localparam int RY_MSB = 4;
  localparam int RY_LSB = 2;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Two's-complement overflow from operand and result sign bits.
  // Add overflows when both operands share a sign the result lacks;
  // subtract overflows when operand signs differ and the result sign
  // differs from the minuend.
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic ovf;
    if (is_sub) begin
      ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/regseq_alu.sv
// regseq_alu: combinational result generator for MOV/ADD/SUB.
// Optional feature macro: REGSEQ_OVF_EN adds the signed overflow output.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_t           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
`ifdef REGSEQ_OVF_EN
  ,
  output logic          ovf
`endif
);

  // Result select; arithmetic wraps modulo 2^DW, carry discarded
  always_comb begin
    result = {DW{1'b0}};
    case (op)
      OP_MOV:  result = b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = {DW{1'b0}};
    endcase
  end

`ifdef REGSEQ_OVF_EN
  // Signed overflow of the selected operation; zero for non-arithmetic ops
  always_comb begin
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = signed_ovf(1'b0, a[DW-1], b[DW-1], result[DW-1]);
      OP_SUB:  ovf = signed_ovf(1'b1, a[DW-1], b[DW-1], result[DW-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: control FSM for the 8 x 10-bit register file.
// Executes LOAD/MOV/ADD/SUB one instruction per Run handshake, all state
// on the falling edge of CLKb. Outputs are decoded from state and IR so an
// asynchronous reset drops them (and any pending write) immediately.
// Optional feature macro: REGSEQ_OVF_EN builds the registered Ovf flag;
// without it Ovf is tied low.
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLKb,
  input  logic          RSTb,
  input  logic          Run,
  input  logic [DW-1:0] Din,
  input  logic [DW-1:0] Q0,
  input  logic [DW-1:0] Q1,
  output logic [DW-1:0] D,
  output logic          ENW,
  output logic          ENR0,
  output logic          ENR1,
  output logic [AW-1:0] WRA,
  output logic [AW-1:0] RDA0,
  output logic [AW-1:0] RDA1,
  output logic          Busy,
  output logic          Done,
  output logic          Ovf
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [OP_MSB:RY_LSB] ir_r;     // reserved bits [1:0] are not kept
  logic [DW-1:0]        a_r;
  logic [DW-1:0]        b_r;
  op_t                  op_s;
  logic [AW-1:0]        rx_s;
  logic [AW-1:0]        ry_s;
  logic [DW-1:0]        alu_result_s;
`ifdef REGSEQ_OVF_EN
  logic                 alu_ovf_s;
  logic                 ovf_r;
`endif

  assign op_s = op_t'(ir_r[OP_MSB:OP_LSB]);
  assign rx_s = AW'(ir_r[RX_MSB:RX_LSB]);
  assign ry_s = AW'(ir_r[RY_MSB:RY_LSB]);

  regseq_alu #(.DW(DW)) u_alu (
    .op     (op_s),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s)
`ifdef REGSEQ_OVF_EN
    ,
    .ovf    (alu_ovf_s)
`endif
  );

  // Next-state logic: LOAD skips EXEC, DONE always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Run) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (op_s == OP_LOAD) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, instruction capture (IDLE only) and operand latch (DECODE)
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_r <= ST_IDLE;
      ir_r    <= {(OP_MSB - RY_LSB + 1){1'b0}};
      a_r     <= {DW{1'b0}};
      b_r     <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && Run) begin
        ir_r <= Din[OP_MSB:RY_LSB];
      end
      if (state_r == ST_DECODE && op_s != OP_LOAD) begin
        a_r <= Q0;
        b_r <= Q1;
      end
    end
  end

`ifdef REGSEQ_OVF_EN
  // Overflow flag: written at the EXEC edge of ADD/SUB, held otherwise
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      ovf_r <= 1'b0;
    end else if (state_r == ST_EXEC && (op_s == OP_ADD || op_s == OP_SUB)) begin
      ovf_r <= alu_ovf_s;
    end
  end

  assign Ovf = ovf_r;
`else
  assign Ovf = 1'b0;
`endif

  // Moore output decode; everything idle-low outside DECODE/EXEC
  always_comb begin
    D    = {DW{1'b0}};
    ENW  = 1'b0;
    ENR0 = 1'b0;
    ENR1 = 1'b0;
    WRA  = {AW{1'b0}};
    RDA0 = {AW{1'b0}};
    RDA1 = {AW{1'b0}};
    Busy = (state_r != ST_IDLE);
    Done = (state_r == ST_DONE);
    case (state_r)
      ST_DECODE: begin
        if (op_s == OP_LOAD) begin
          // immediate data word is presented on Din during this cycle
          ENW = 1'b1;
          WRA = rx_s;
          D   = Din;
        end else begin
          ENR0 = 1'b1;
          RDA0 = rx_s;
          ENR1 = 1'b1;
          RDA1 = ry_s;
        end
      end
      ST_EXEC: begin
        ENW = 1'b1;
        WRA = rx_s;
        D   = alu_result_s;
      end
      default: begin
        D = {DW{1'b0}};
      end
    endcase
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Control FSM that drives the 8 × 10-bit register file in our datapath. It accepts one 10-bit instruction per `Run` handshake on `Din` and generates the register file's `ENW`, `ENR0`, `ENR1`, `WRA`, `RDA0`, `RDA1` and `D` signals. It executes LOAD, MOV, ADD and SUB, then pulses `Done`. It sits between the instruction/switch input bus and the register file, and its ALU result is the register file's only write-data source.

## Interface
Parameters:
- `DW`, 10: datapath/register width.
- `AW`, 3: register address width (8 registers).

Ports (name, direction, width, meaning):
- `CLKb` in 1: clock; all state updates on the falling edge.
- `RSTb` in 1: asynchronous, active-low reset.
- `Run` in 1: instruction-valid request; sampled only in IDLE.
- `Din` in DW: instruction word. During a LOAD, it also carries the immediate data word.
- `Q0` in DW: register file read port 0 data.
- `Q1` in DW: register file read port 1 data.
- `D` out DW: register file write data.
- `ENW` out 1: register file write enable.
- `ENR0` out 1: read port 0 enable.
- `ENR1` out 1: read port 1 enable.
- `WRA` out AW: write address.
- `RDA0` out AW: read address for port 0.
- `RDA1` out AW: read address for port 1.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle completion pulse.
- `Ovf` out 1: signed overflow flag of the last ADD/SUB. Present only with the macro; see Configuration.

## Operation
- Instruction format:
  - `op` = `Din[9:8]`: 00 LOAD, 01 MOV, 10 ADD, 11 SUB.
  - `rx` = `Din[7:5]`: destination and first operand.
  - `ry` = `Din[4:2]`: second operand.
  - `Din[1:0]`: reserved, ignored.
- State machine: IDLE, DECODE, EXEC, DONE.
- IDLE:
  - On a falling edge with `Run`=1, capture `Din` into IR and go to DECODE.
  - With `Run`=0, remain in IDLE.
- DECODE, when IR.op = LOAD:
  - Drive `ENW`=1, `WRA`=rx, `D`=`Din`. The write happens at the closing edge.
  - Next state: DONE.
- DECODE, all other ops:
  - Drive `ENR0`=1, `RDA0`=rx, `ENR1`=1, `RDA1`=ry.
  - Latch `Q0`→A and `Q1`→B at the closing edge.
  - Next state: EXEC.
- EXEC:
  - Drive `ENW`=1, `WRA`=rx, `D`=result.
  - Result: MOV = B; ADD = A+B; SUB = A−B.
  - Next state: DONE.
- DONE: `Done`=1 for exactly one cycle, then return to IDLE unconditionally.
- Arithmetic: unsigned DW-bit, wraps modulo 2^DW; the carry is discarded.
- Outputs are Moore-decoded from state and IR.
  - Outside the cycles listed above: all enables 0, all addresses 0, `D`=0.
- rx == ry is legal: operands are read before the write. ADD r3,r3 doubles r3.
- `Run` outside IDLE is ignored. It is not queued.

## Timing
- Reset values while `RSTb`=0:
  - State = IDLE; IR, A, B = 0.
  - `D`=0, `ENW`=`ENR0`=`ENR1`=0, `WRA`=`RDA0`=`RDA1`=0.
  - `Busy`=0, `Done`=0, `Ovf`=0.
- Reset mid-operation: outputs go immediately to their reset values. Any in-flight write is abandoned and no register is modified.
- LOAD latency: `Run` edge → write at edge +1 → `Done` high in the following cycle. Total 3 cycles from `Run` sample back to IDLE.
- MOV/ADD/SUB latency: `Run` edge → operand latch at +1 → write at +2 → `Done` in the following cycle. Total 4 cycles.
- `Run` held high continuously: the next instruction is sampled in the IDLE cycle after DONE. There is therefore one IDLE cycle between instructions.
- The LOAD data word on `Din` must be stable throughout the DECODE cycle.

## Configuration
- `REGSEQ_OVF_EN` defined:
  - `Ovf` is a register updated at the EXEC write edge of ADD/SUB only.
  - Value is the two's-complement signed overflow of the operation.
  - Held through LOAD, MOV and idle cycles.
- `REGSEQ_OVF_EN` undefined: `Ovf` is tied to 0 and no overflow logic is built.

## Structure
- Package `regseq_pkg` holds:
  - `DW`/`AW` defaults.
  - The `op_t` enum (LOAD, MOV, ADD, SUB).
  - The `state_t` enum (IDLE, DECODE, EXEC, DONE).
  - The instruction field bit positions.
- Sub-module `regseq_alu`: combinational; takes op, A and B; produces the result and the overflow bit.
- FSM, IR/A/B registers and output decode stay in `regfile_sequencer`.

## Test plan
- LOAD: Run with `Din`=0b00_011_000_00, then `Din`=0x155 in DECODE. Expect `ENW`=1, `WRA`=3, `D`=0x155 at the write edge; `Done` one cycle later; `Busy` low after.
- MOV: r3=0x155, r1=0; MOV r1,r3. Expect reads with `RDA0`=1, `RDA1`=3, then write `WRA`=1, `D`=0x155; total 4 cycles.
- ADD wrap with `REGSEQ_OVF_EN`: r2=0x3FF, r4=0x002; ADD r2,r4. Expect `D`=0x001, `Ovf`=0 (−1+2). Then r5=0x1FF, r6=0x001; ADD r5,r6. Expect `D`=0x200, `Ovf`=1.
- SUB with rx==ry: r7=0x0AA; SUB r7,r7. Expect `D`=0x000, `WRA`=7.
- Run ignored while busy: `Run`=1 during the DECODE and EXEC cycles of an ADD. Expect no extra instruction capture. With `Run` held high, the next instruction is sampled exactly one cycle after `Done`.
- Reset mid-op: assert `RSTb`=0 during EXEC. Expect `ENW` to drop immediately, the target register unchanged, and all outputs at reset values.
